// File: rtl/roe_pkg.sv
// roe_pkg -- shared widths, opcodes and the fetch-state encoding for the
// instruction fetch unit.
//   PC_W        fetch address width
//   INSTR_W     instruction word width
//   OP_SETPA    instr[8:5] opcode that requests a register-page header update
//   HALT_INSTR  instruction word that stops fetching
//   setpa_of()  builds the {enable, pa[1:0]} request for a decoded word
package roe_pkg;

   localparam int                 PC_W       = 10;
   localparam int                 INSTR_W    = 9;
   localparam logic [3:0]         OP_SETPA   = 4'b1110;
   localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   // Header-update request: enabled only for a live word carrying OP_SETPA.
   function automatic logic [2:0] setpa_of(input logic valid,
                                           input logic [INSTR_W-1:0] word);
      logic [2:0] res;
      if (valid && (word[INSTR_W-1:INSTR_W-4] == OP_SETPA)) begin
         res = {1'b1, word[1:0]};
      end else begin
         res = 3'b000;
      end
      return res;
   endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// pc_reg -- fetch-address register that drives the instruction ROM address.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load_en      load load_addr (start or branch redirect); wins over inc_en
//   load_addr    absolute address to load
//   inc_en       advance by one, wrapping from the top address to 0
//   addr         current fetch address (registered)
// With neither load_en nor inc_en the address holds.
module pc_reg
   import roe_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_en,
   input  logic [PC_W-1:0] load_addr,
   input  logic            inc_en,
   output logic [PC_W-1:0] addr
);

   logic [PC_W-1:0] addr_d;
   logic [PC_W-1:0] addr_q;

   // Next-address select: load, increment (natural wrap) or hold.
   always_comb begin
      addr_d = addr_q;
      if (load_en) begin
         addr_d = load_addr;
      end else if (inc_en) begin
         addr_d = addr_q + PC_W'(1);
      end else begin
         addr_d = addr_q;
      end
   end

   // Address register with synchronous reset to 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- three-state (IDLE/RUN/HALT) fetch unit in front of a
// synchronous-read instruction ROM.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start            begin execution at address 0 from IDLE or HALT
//   stall            freeze the whole fetch pipeline
//   branch_taken     redirect to branch_target (squashes in-flight words)
//   imem_addr        ROM address, imem_data ROM word for the previous address
//   instr, pc        registered instruction and its address
//   instr_valid      instr is live and unsquashed
//   set_pa           {enable, pa[1:0]} header-update request
//   reg_field        instr[1:0]
//   halted           fetch stopped on the HALT word
// Pipeline: imem_addr -> (ROM) imem_data -> instr, so a word reaches instr two
// edges after its address is loaded.
module instr_fetch
   import roe_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc,
   output logic [2:0]         set_pa,
   output logic [1:0]         reg_field,
   output logic               halted
);

   fetch_state_e       state_d,       state_q;
   logic               f_valid_d,     f_valid_q;     // imem_data is a real fetch
   logic [PC_W-1:0]    f_pc_d,        f_pc_q;        // address of imem_data
   logic [INSTR_W-1:0] skid_d,        skid_q;        // in-flight word saved on stall
   logic               skid_valid_d,  skid_valid_q;
   logic [INSTR_W-1:0] instr_d,       instr_q;
   logic               instr_valid_d, instr_valid_q;
   logic [PC_W-1:0]    pc_d,          pc_q;
   logic [2:0]         set_pa_d,      set_pa_q;
   logic               halted_d,      halted_q;

   logic               pc_load_s;
   logic [PC_W-1:0]    pc_load_addr_s;
   logic               pc_inc_s;
   logic               hit_halt_s;
   logic [INSTR_W-1:0] eff_data_s;

   pc_reg u_pc_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (pc_load_s),
      .load_addr (pc_load_addr_s),
      .inc_en    (pc_inc_s),
      .addr      (imem_addr)
   );

   assign hit_halt_s = instr_valid_q && (instr_q == HALT_INSTR);
   // The ROM keeps reading the held address during a stall, so the word that
   // was in flight when the stall began lives in the skid register instead.
   assign eff_data_s = skid_valid_q ? skid_q : imem_data;

   // Fetch FSM, pipeline advance, squash and stall hold.
   always_comb begin
      state_d        = state_q;
      f_valid_d      = f_valid_q;
      f_pc_d         = f_pc_q;
      skid_d         = skid_q;
      skid_valid_d   = skid_valid_q;
      instr_d        = instr_q;
      instr_valid_d  = instr_valid_q;
      pc_d           = pc_q;
      halted_d       = halted_q;
      pc_load_s      = 1'b0;
      pc_load_addr_s = '0;
      pc_inc_s       = 1'b0;

      if (stall) begin
         // Capture the in-flight word only on the first stalled edge.
         if (!skid_valid_q) begin
            skid_d       = imem_data;
            skid_valid_d = 1'b1;
         end else begin
            skid_d       = skid_q;
            skid_valid_d = 1'b1;
         end
      end else begin
         skid_valid_d = 1'b0;
         case (state_q)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state_d        = ST_RUN;
                  pc_load_s      = 1'b1;
                  pc_load_addr_s = '0;
                  f_valid_d      = 1'b0;
                  instr_valid_d  = 1'b0;
                  halted_d       = 1'b0;
               end else begin
                  state_d = state_q;
               end
            end
            ST_RUN: begin
               if (branch_taken) begin
                  // Both the word on imem_data and the one being read now die.
                  pc_load_s      = 1'b1;
                  pc_load_addr_s = branch_target;
                  f_valid_d      = 1'b0;
                  f_pc_d         = imem_addr;
                  instr_valid_d  = 1'b0;
               end else if (hit_halt_s) begin
                  state_d       = ST_HALT;
                  halted_d      = 1'b1;
                  instr_valid_d = 1'b0;
                  f_valid_d     = 1'b0;
               end else begin
                  pc_inc_s      = 1'b1;
                  f_valid_d     = 1'b1;
                  f_pc_d        = imem_addr;
                  instr_valid_d = f_valid_q;
                  // Squashed words leave instr/pc untouched.
                  if (f_valid_q) begin
                     instr_d = eff_data_s;
                     pc_d    = f_pc_q;
                  end else begin
                     instr_d = instr_q;
                     pc_d    = pc_q;
                  end
               end
            end
            default: begin
               state_d       = ST_IDLE;
               f_valid_d     = 1'b0;
               instr_valid_d = 1'b0;
               halted_d      = 1'b0;
            end
         endcase
      end

      set_pa_d = setpa_of(instr_valid_d, instr_d);
   end

   // State and output registers, all cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         f_valid_q     <= 1'b0;
         f_pc_q        <= '0;
         skid_q        <= '0;
         skid_valid_q  <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         pc_q          <= '0;
         set_pa_q      <= 3'b000;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         f_valid_q     <= f_valid_d;
         f_pc_q        <= f_pc_d;
         skid_q        <= skid_d;
         skid_valid_q  <= skid_valid_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         pc_q          <= pc_d;
         set_pa_q      <= set_pa_d;
         halted_q      <= halted_d;
      end
   end

   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign set_pa      = set_pa_q;
   assign reg_field   = instr_q[1:0];
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- directed bench for instr_fetch with a synchronous ROM model.
// ROM: word i = {1'b0, i[7:0]} except ROM[0..3] = 1C1/005/00A/1FF and
// ROM[200h] = 1C6 (a header-update word with pa = 2'b10).
module tb_instr_fetch;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stall;
   logic       branch_taken;
   logic [9:0] branch_target;
   logic [9:0] imem_addr;
   logic [8:0] imem_data;
   logic [8:0] instr;
   logic       instr_valid;
   logic [9:0] pc;
   logic [2:0] set_pa;
   logic [1:0] reg_field;
   logic       halted;

   logic [8:0] rom [0:1023];
   int         total;
   int         bad;

   instr_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .set_pa        (set_pa),
      .reg_field     (reg_field),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read ROM, one cycle of latency.
   always @(posedge clk) imem_data <= rom[imem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [9:0] e_addr, input logic [8:0] e_instr,
                          input logic e_valid, input logic [9:0] e_pc, input logic [2:0] e_setpa,
                          input logic e_halted);
      logic [1:0] e_rf;
      e_rf = e_instr[1:0];
      chk({tag, ".imem_addr"},   32'(imem_addr),   32'(e_addr));
      chk({tag, ".instr"},       32'(instr),       32'(e_instr));
      chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
      chk({tag, ".pc"},          32'(pc),          32'(e_pc));
      chk({tag, ".set_pa"},      32'(set_pa),      32'(e_setpa));
      chk({tag, ".reg_field"},   32'(reg_field),   32'(e_rf));
      chk({tag, ".halted"},      32'(halted),      32'(e_halted));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 1024; i++) begin
         logic [9:0] a;
         a = 10'(i);
         rom[i] = {1'b0, a[7:0]};
      end
      rom[0]      = 9'h1C1;
      rom[1]      = 9'h005;
      rom[2]      = 9'h00A;
      rom[3]      = 9'h1FF;
      rom[10'h200] = 9'h1C6;

      rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 10'h000;
      tick(); tick();
      chk_all("rst",      10'h000, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      rst_n = 1'b1;
      tick();
      chk_all("idle",     10'h000, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      branch_taken = 1'b1; branch_target = 10'h200;
      tick(); branch_taken = 1'b0;
      chk_all("idle_br",  10'h000, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);

      // Basic stream to HALT
      start = 1'b1; tick(); start = 1'b0;
      chk_all("s0",  10'h000, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      tick(); chk_all("s1",  10'h001, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      tick(); chk_all("s2",  10'h002, 9'h1C1, 1'b1, 10'h000, 3'b101, 1'b0);
      tick(); chk_all("s3",  10'h003, 9'h005, 1'b1, 10'h001, 3'b000, 1'b0);
      tick(); chk_all("s4",  10'h004, 9'h00A, 1'b1, 10'h002, 3'b000, 1'b0);
      tick(); chk_all("s5",  10'h005, 9'h1FF, 1'b1, 10'h003, 3'b000, 1'b0);
      tick(); chk_all("h0",  10'h005, 9'h1FF, 1'b0, 10'h003, 3'b000, 1'b1);
      branch_taken = 1'b1; branch_target = 10'h200;
      tick(); branch_taken = 1'b0;
      chk_all("h_br", 10'h005, 9'h1FF, 1'b0, 10'h003, 3'b000, 1'b1);

      // Restart from HALT, then stall three cycles with branch/start ignored
      start = 1'b1; tick(); start = 1'b0;
      chk_all("r0",  10'h000, 9'h1FF, 1'b0, 10'h003, 3'b000, 1'b0);
      tick(); chk_all("r1",  10'h001, 9'h1FF, 1'b0, 10'h003, 3'b000, 1'b0);
      tick(); chk_all("r2",  10'h002, 9'h1C1, 1'b1, 10'h000, 3'b101, 1'b0);
      stall = 1'b1; branch_taken = 1'b1; branch_target = 10'h200;
      tick(); chk_all("st1", 10'h002, 9'h1C1, 1'b1, 10'h000, 3'b101, 1'b0);
      tick(); chk_all("st2", 10'h002, 9'h1C1, 1'b1, 10'h000, 3'b101, 1'b0);
      start = 1'b1;
      tick(); chk_all("st3", 10'h002, 9'h1C1, 1'b1, 10'h000, 3'b101, 1'b0);
      stall = 1'b0; branch_taken = 1'b0; start = 1'b0;
      tick(); chk_all("rs1", 10'h003, 9'h005, 1'b1, 10'h001, 3'b000, 1'b0);
      tick(); chk_all("rs2", 10'h004, 9'h00A, 1'b1, 10'h002, 3'b000, 1'b0);

      // Branch to 200h
      branch_taken = 1'b1; branch_target = 10'h200;
      tick(); branch_taken = 1'b0;
      chk_all("b0",  10'h200, 9'h00A, 1'b0, 10'h002, 3'b000, 1'b0);
      tick(); chk_all("b1",  10'h201, 9'h00A, 1'b0, 10'h002, 3'b000, 1'b0);
      tick(); chk_all("b2",  10'h202, 9'h1C6, 1'b1, 10'h200, 3'b110, 1'b0);
      tick(); chk_all("b3",  10'h203, 9'h001, 1'b1, 10'h201, 3'b000, 1'b0);

      // Branch to 1022 and wrap through 0
      branch_taken = 1'b1; branch_target = 10'd1022;
      tick(); branch_taken = 1'b0;
      chk_all("w0",  10'h3FE, 9'h001, 1'b0, 10'h201, 3'b000, 1'b0);
      tick(); chk_all("w1",  10'h3FF, 9'h001, 1'b0, 10'h201, 3'b000, 1'b0);
      tick(); chk_all("w2",  10'h000, 9'h0FE, 1'b1, 10'h3FE, 3'b000, 1'b0);
      tick(); chk_all("w3",  10'h001, 9'h0FF, 1'b1, 10'h3FF, 3'b000, 1'b0);
      tick(); chk_all("w4",  10'h002, 9'h1C1, 1'b1, 10'h000, 3'b101, 1'b0);
      tick(); chk_all("w5",  10'h003, 9'h005, 1'b1, 10'h001, 3'b000, 1'b0);
      tick(); chk_all("w6",  10'h004, 9'h00A, 1'b1, 10'h002, 3'b000, 1'b0);
      tick(); chk_all("w7",  10'h005, 9'h1FF, 1'b1, 10'h003, 3'b000, 1'b0);

      // Branch beats a valid HALT on instr
      branch_taken = 1'b1; branch_target = 10'h200;
      tick(); branch_taken = 1'b0;
      chk_all("hb0", 10'h200, 9'h1FF, 1'b0, 10'h003, 3'b000, 1'b0);
      tick(); chk_all("hb1", 10'h201, 9'h1FF, 1'b0, 10'h003, 3'b000, 1'b0);
      tick(); chk_all("hb2", 10'h202, 9'h1C6, 1'b1, 10'h200, 3'b110, 1'b0);

      // Reset mid-RUN beats start and branch, then re-execute from 0
      rst_n = 1'b0; start = 1'b1; branch_taken = 1'b1; branch_target = 10'h3FE;
      tick(); chk_all("mr", 10'h000, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      rst_n = 1'b1; start = 1'b0; branch_taken = 1'b0;
      tick(); chk_all("mr_idle", 10'h000, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      chk_all("m0", 10'h000, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      tick(); chk_all("m1", 10'h001, 9'h000, 1'b0, 10'h000, 3'b000, 1'b0);
      tick(); chk_all("m2", 10'h002, 9'h1C1, 1'b1, 10'h000, 3'b101, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      chk_all("m3", 10'h003, 9'h005, 1'b1, 10'h001, 3'b000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
